// File: rtl/fg_bd_arbiter.sv
// fg_bd_arbiter: round-robin merge of per-flow burst descriptor streams onto
// one registered output. Supports per-port enables and a soft throttle driven by
// the downstream FIFO byte count. Each forwarded descriptor is tagged with the
// index of the port it came from.
module fg_bd_arbiter #(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned PORT_WIDTH = 2,
  parameter int unsigned DEST_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            input_bd_valid,
  output logic [PORTS-1:0]            input_bd_ready,
  input  logic [PORTS*DEST_WIDTH-1:0] input_bd_dest,
  input  logic [PORTS*32-1:0]         input_bd_burst_len,
  output logic                        output_bd_valid,
  input  logic                        output_bd_ready,
  output logic [DEST_WIDTH-1:0]       output_bd_dest,
  output logic [31:0]                 output_bd_burst_len,
  output logic [PORT_WIDTH-1:0]       output_bd_port,
  input  logic [PORTS-1:0]            enable,
  input  logic [ADDR_WIDTH+31:0]      fifo_byte_count,
  input  logic [ADDR_WIDTH+31:0]      byte_limit,
  output logic [31:0]                 burst_count
);

  localparam int unsigned BC_WIDTH = ADDR_WIDTH + 32;
  localparam int unsigned NPAD     = 1 << PORT_WIDTH;
  localparam int unsigned CW       = PORT_WIDTH + 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DEST_WIDTH-1:0]   r_dest;
  logic [31:0]             r_len;
  logic [PORT_WIDTH-1:0]   r_port;
  logic [PORT_WIDTH-1:0]   r_rr_ptr;
  logic [31:0]             r_burst_count;

  logic                    w_throttle;
  logic                    w_load;
  logic                    w_handshake;
  logic [PORTS-1:0]        w_req;
  logic [NPAD-1:0]         w_req_pad;
  logic [CW-1:0]           w_cand;
  logic                    w_found;
  logic [PORT_WIDTH-1:0]   w_idx;
  logic                    w_grant;
  logic [PORT_WIDTH-1:0]   w_rr_nxt;
  logic [DEST_WIDTH-1:0]   w_sel_dest;
  logic [31:0]             w_sel_len;
  logic [PORTS-1:0]        w_ready;

  assign output_bd_valid     = (r_state == ST_FULL);
  assign output_bd_dest      = r_dest;
  assign output_bd_burst_len = r_len;
  assign output_bd_port      = r_port;
  assign burst_count         = r_burst_count;
  assign input_bd_ready      = w_ready;

  assign w_throttle  = (byte_limit != BC_WIDTH'(0)) && (fifo_byte_count >= byte_limit);
  assign w_load      = (!output_bd_valid || output_bd_ready) && !w_throttle && !rst;
  assign w_handshake = output_bd_valid && output_bd_ready;
  assign w_req       = input_bd_valid & enable;
  assign w_req_pad   = NPAD'(w_req);
  assign w_grant     = w_load && w_found;
  assign w_rr_nxt    = (w_idx == PORT_WIDTH'(PORTS - 1)) ? '0 : w_idx + PORT_WIDTH'(1);

  // Round-robin search: first requesting port at or above r_rr_ptr, wrapping
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int i = 0; i < PORTS; i++) begin
      w_cand = CW'(r_rr_ptr) + CW'(i);
      if (w_cand >= CW'(PORTS)) begin
        w_cand = w_cand - CW'(PORTS);
      end
      if (!w_found && w_req_pad[w_cand[PORT_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_cand[PORT_WIDTH-1:0];
      end
    end
  end

  // Select granted port's payload and drive the one-hot accept
  always_comb begin
    w_sel_dest = '0;
    w_sel_len  = '0;
    w_ready    = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (w_idx == PORT_WIDTH'(i)) begin
        w_sel_dest = input_bd_dest[i*DEST_WIDTH +: DEST_WIDTH];
        w_sel_len  = input_bd_burst_len[i*32 +: 32];
      end
      w_ready[i] = w_grant && (w_idx == PORT_WIDTH'(i));
    end
  end

  // Next-state: output register occupancy
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_grant) w_state_nxt = ST_FULL;
      ST_FULL:  if (output_bd_ready && !w_grant) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output payload and round-robin pointer; payload holds after drain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dest   <= '0;
      r_len    <= '0;
      r_port   <= '0;
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_dest   <= w_sel_dest;
      r_len    <= w_sel_len;
      r_port   <= w_idx;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Output handshake counter, free-running wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst_count <= '0;
    end else if (w_handshake) begin
      r_burst_count <= r_burst_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fg_bd_arbiter.sv
// tb_fg_bd_arbiter: directed checks of fg_bd_arbiter with hand-computed expectations.
module tb_fg_bd_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   valid;
  logic [3:0]   in_ready;
  logic [31:0]  dest_bus;
  logic [127:0] len_bus;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_dest;
  logic [31:0]  out_len;
  logic [1:0]   out_port;
  logic [3:0]   en;
  logic [41:0]  fifo_cnt;
  logic [41:0]  limit;
  logic [31:0]  bcount;

  int n_cmp;
  int n_bad;

  fg_bd_arbiter #(
    .PORTS(4), .PORT_WIDTH(2), .DEST_WIDTH(8), .ADDR_WIDTH(10)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .input_bd_valid      (valid),
    .input_bd_ready      (in_ready),
    .input_bd_dest       (dest_bus),
    .input_bd_burst_len  (len_bus),
    .output_bd_valid     (out_valid),
    .output_bd_ready     (out_ready),
    .output_bd_dest      (out_dest),
    .output_bd_burst_len (out_len),
    .output_bd_port      (out_port),
    .enable              (en),
    .fifo_byte_count     (fifo_cnt),
    .byte_limit          (limit),
    .burst_count         (bcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Port i: dest 0x10+i, len 16*(i+2) -> port 2 carries dest 0x12, len 64
  function automatic logic [7:0] exp_dest(input int p);
    return 8'(8'h10 + p);
  endfunction

  function automatic logic [31:0] exp_len(input int p);
    return 32'(16 * (p + 2));
  endfunction

  initial begin
    logic [3:0] e;
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 4; i++) begin
      dest_bus[i*8 +: 8]   = exp_dest(i);
      len_bus[i*32 +: 32]  = exp_len(i);
    end
    rst       = 1'b1;
    valid     = 4'hF;
    en        = 4'hF;
    out_ready = 1'b1;
    fifo_cnt  = '0;
    limit     = '0;

    // Reset: no accept while rst is high, all outputs zero
    #1;
    chk("rst_ready_pre", 64'(in_ready), 64'h0);
    tick();
    chk("rst_ready", 64'(in_ready), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_dest",  64'(out_dest), 64'h0);
    chk("rst_len",   64'(out_len), 64'h0);
    chk("rst_port",  64'(out_port), 64'h0);
    chk("rst_count", 64'(bcount), 64'h0);
    rst   = 1'b0;
    valid = 4'h0;

    // Single request from port 2
    valid = 4'b0100;
    #1 chk("t1_ready", 64'(in_ready), 64'b0100);
    tick();
    valid = 4'h0;
    #1;
    chk("t1_valid", 64'(out_valid), 64'h1);
    chk("t1_dest",  64'(out_dest), 64'h12);
    chk("t1_len",   64'(out_len), 64'd64);
    chk("t1_port",  64'(out_port), 64'd2);
    chk("t1_ready_idle", 64'(in_ready), 64'h0);
    tick();
    chk("t1_count", 64'(bcount), 64'd1);
    chk("t1_drained", 64'(out_valid), 64'h0);

    // All ports continuous: 0,1,2,3,0,1,2,3 back to back
    do_reset();
    valid = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e = 4'b0001 << (k % 4);
      #1 chk("t2_ready", 64'(in_ready), 64'(e));
      tick();
      chk("t2_port", 64'(out_port), 64'(k % 4));
      chk("t2_dest", 64'(out_dest), 64'(exp_dest(k % 4)));
    end
    valid = 4'h0;
    tick();
    chk("t2_count", 64'(bcount), 64'd8);
    chk("t2_drained", 64'(out_valid), 64'h0);

    // Backpressure: held descriptor stable, no grants for 5 cycles
    do_reset();
    valid = 4'hF;
    out_ready = 1'b0;
    #1 chk("t3_first", 64'(in_ready), 64'b0001);
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_hold_ready", 64'(in_ready), 64'h0);
      chk("t3_hold_valid", 64'(out_valid), 64'h1);
      chk("t3_hold_port",  64'(out_port), 64'd0);
      chk("t3_hold_len",   64'(out_len), 64'(exp_len(0)));
      tick();
    end
    out_ready = 1'b1;
    #1 chk("t3_release", 64'(in_ready), 64'b0010);
    tick();
    chk("t3_port", 64'(out_port), 64'd1);
    chk("t3_count", 64'(bcount), 64'd1);

    // Throttle: held descriptor drains, grants blocked at limit
    do_reset();
    limit = 42'd1000;
    fifo_cnt = 42'd0;
    valid = 4'b0010;
    out_ready = 1'b0;
    tick();
    chk("t4_held", 64'(out_port), 64'd1);
    fifo_cnt = 42'd1000;
    valid = 4'hF;
    out_ready = 1'b1;
    #1;
    chk("t4_block", 64'(in_ready), 64'h0);
    chk("t4_present", 64'(out_valid), 64'h1);
    tick();
    chk("t4_drained", 64'(out_valid), 64'h0);
    chk("t4_count", 64'(bcount), 64'd1);
    #1 chk("t4_block2", 64'(in_ready), 64'h0);
    fifo_cnt = 42'd999;
    #1 chk("t4_resume", 64'(in_ready), 64'b0100);
    tick();
    chk("t4_port", 64'(out_port), 64'd2);
    limit = 42'd0;
    fifo_cnt = '1;
    #1 chk("t4_nolimit", 64'(in_ready), 64'b1000);
    tick();
    chk("t4_port3", 64'(out_port), 64'd3);
    fifo_cnt = 42'd0;

    // Enables 1010: ports 1 and 3 alternate
    do_reset();
    en = 4'b1010;
    valid = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 1) ? 4'b1000 : 4'b0010;
      #1 chk("t5_ready", 64'(in_ready), 64'(e));
      tick();
      chk("t5_port", 64'(out_port), 64'((k % 2 == 1) ? 3 : 1));
    end
    en = 4'hF;

    // Reset mid-operation discards the held descriptor
    do_reset();
    valid = 4'hF;
    out_ready = 1'b1;
    tick();
    tick();
    chk("t6_pre_count", 64'(bcount), 64'd1);
    chk("t6_pre_port", 64'(out_port), 64'd1);
    rst = 1'b1;
    #1 chk("t6_rst_ready", 64'(in_ready), 64'h0);
    tick();
    chk("t6_valid", 64'(out_valid), 64'h0);
    chk("t6_dest",  64'(out_dest), 64'h0);
    chk("t6_len",   64'(out_len), 64'h0);
    chk("t6_port",  64'(out_port), 64'h0);
    chk("t6_count", 64'(bcount), 64'h0);
    rst = 1'b0;
    valid = 4'b0110;
    #1 chk("t6_first", 64'(in_ready), 64'b0010);
    tick();
    chk("t6_out_port", 64'(out_port), 64'd1);
    chk("t6_out_dest", 64'(out_dest), 64'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
